// File: rtl/instr_fetch.sv
// RV32I instruction fetch: PC register, in-order imem request/grant issue, response FIFO,
// and redirect handling that discards responses to requests made before the redirect.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  localparam int         INST_SIZE = 32
) (
  input  logic                 i_aclk,
  input  logic                 i_areset_n,
  input  logic                 i_stall,
  input  logic                 i_dec_redirect,
  input  logic [INST_SIZE-1:0] i_dec_redirect_addr,
  input  logic                 i_ex_redirect,
  input  logic [INST_SIZE-1:0] i_ex_redirect_addr,
  output logic                 o_imem_req,
  output logic [INST_SIZE-1:0] o_imem_addr,
  input  logic                 i_imem_gnt,
  input  logic                 i_imem_rvalid,
  input  logic [INST_SIZE-1:0] i_imem_rdata,
  output logic                 o_valid,
  output logic [INST_SIZE-1:0] o_instruction,
  output logic [INST_SIZE-1:0] o_pc,
  output logic [INST_SIZE-1:0] o_pcplus4
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 2;
  localparam logic [6:0] NOOP_CODE = 7'b000_0000;
  localparam logic [INST_SIZE-1:0] NOOP = {{(INST_SIZE-7){1'b0}}, NOOP_CODE};

  logic [INST_SIZE-1:0] r_pc;
  logic [INST_SIZE-1:0] r_fifo_instr [DEPTH];
  logic [INST_SIZE-1:0] r_fifo_pc    [DEPTH];
  logic [AW-1:0]        r_fifo_wr;
  logic [AW-1:0]        r_fifo_rd;
  logic [CW-1:0]        r_count;
  logic [INST_SIZE-1:0] r_addr_mem   [DEPTH];
  logic [AW-1:0]        r_addr_wr;
  logic [AW-1:0]        r_addr_rd;
  logic [CW-1:0]        r_outstanding;
  logic [CW-1:0]        r_drop;

  logic                 w_redirect;
  logic [INST_SIZE-1:0] w_target;
  logic                 w_head_valid;
  logic                 w_pop;
  logic                 w_rsp_keep;
  logic                 w_rsp_drop;
  logic                 w_req;
  logic                 w_issue;
  logic                 w_gnt_cnt;
  logic [CW-1:0]        w_out_next;
  logic [SW-1:0]        w_occ;
  logic [SW-1:0]        w_lim;

  assign w_redirect   = i_dec_redirect | i_ex_redirect;
  assign w_target     = i_ex_redirect ? i_ex_redirect_addr : i_dec_redirect_addr;
  assign w_head_valid = (r_count != '0);
  assign w_pop        = w_head_valid & ~i_stall & ~w_redirect;
  assign w_rsp_keep   = i_imem_rvalid & (r_drop == '0);
  assign w_rsp_drop   = i_imem_rvalid & (r_drop != '0);

  // A slot freed this cycle (head consumed or stale response discarded) may be reused
  // by this cycle's request, which is what keeps one-per-cycle throughput at DEPTH = 2.
  always_comb begin
    w_occ = SW'(r_outstanding) + SW'(r_count);
    w_lim = SW'(DEPTH) + SW'(w_pop) + SW'(w_rsp_drop);
    w_req = i_areset_n & ~w_redirect & (w_occ < w_lim);
  end

  assign w_issue    = w_req & i_imem_gnt;
  assign w_gnt_cnt  = i_imem_gnt & (w_req | w_redirect);
  assign w_out_next = r_outstanding + CW'(w_gnt_cnt) - CW'(i_imem_rvalid);

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_addr_wr     <= '0;
      r_addr_rd     <= '0;
      r_fifo_wr     <= '0;
      r_fifo_rd     <= '0;
      r_count       <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (w_redirect) begin
        // Everything still in flight after this edge belongs to the old path.
        r_pc      <= w_target & 32'hFFFF_FFFC;
        r_drop    <= w_out_next;
        r_addr_wr <= '0;
        r_addr_rd <= '0;
        r_fifo_wr <= '0;
        r_fifo_rd <= '0;
        r_count   <= '0;
      end else begin
        if (w_issue) begin
          r_pc      <= r_pc + 32'd4;
          r_addr_wr <= r_addr_wr + AW'(1);
        end
        if (w_rsp_drop) begin
          r_drop <= r_drop - CW'(1);
        end
        if (w_rsp_keep) begin
          r_addr_rd <= r_addr_rd + AW'(1);
          r_fifo_wr <= r_fifo_wr + AW'(1);
        end
        if (w_pop) begin
          r_fifo_rd <= r_fifo_rd + AW'(1);
        end
        r_count <= r_count + CW'(w_rsp_keep) - CW'(w_pop);
      end
    end
  end

  // Storage arrays need no reset; validity is tracked by the pointers and counters.
  always_ff @(posedge i_aclk) begin
    if (w_issue) begin
      r_addr_mem[r_addr_wr] <= r_pc;
    end
    if (w_rsp_keep && !w_redirect) begin
      r_fifo_instr[r_fifo_wr] <= i_imem_rdata;
      r_fifo_pc[r_fifo_wr]    <= r_addr_mem[r_addr_rd];
    end
  end

  assign o_imem_req    = w_req;
  assign o_imem_addr   = r_pc;
  assign o_valid       = w_head_valid;
  assign o_instruction = w_head_valid ? r_fifo_instr[r_fifo_rd] : NOOP;
  assign o_pc          = w_head_valid ? r_fifo_pc[r_fifo_rd] : '0;
  assign o_pcplus4     = w_head_valid ? (r_fifo_pc[r_fifo_rd] + 32'd4) : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: an in-order imem model with configurable latency and
// grant rate, a stimulus process that queues the expected PC stream, and a consume monitor.
`timescale 1ns/1ps
module tb_instr_fetch;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    int          ready;
  } pend_t;

  logic        clk = 1'b0;
  logic        i_areset_n;
  logic        i_stall;
  logic        i_dec_redirect;
  logic [31:0] i_dec_redirect_addr;
  logic        i_ex_redirect;
  logic [31:0] i_ex_redirect_addr;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_valid;
  logic [31:0] o_instruction;
  logic [31:0] o_pc;
  logic [31:0] o_pcplus4;

  pend_t       pendQ[$];
  pend_t       memP;
  logic [31:0] expQ[$];
  logic        gntEn;
  int          numChecks = 0;
  int          numFails = 0;
  int          cycle = 0;
  int          epochConsumed = 0;
  int          totalConsumed = 0;
  int          latMin = 1;
  int          latMax = 1;
  int          gntPct = 100;
  int          lastReady = 0;

  instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .i_aclk              (clk),
    .i_areset_n          (i_areset_n),
    .i_stall             (i_stall),
    .i_dec_redirect      (i_dec_redirect),
    .i_dec_redirect_addr (i_dec_redirect_addr),
    .i_ex_redirect       (i_ex_redirect),
    .i_ex_redirect_addr  (i_ex_redirect_addr),
    .o_imem_req          (o_imem_req),
    .o_imem_addr         (o_imem_addr),
    .i_imem_gnt          (i_imem_gnt),
    .i_imem_rvalid       (i_imem_rvalid),
    .i_imem_rdata        (i_imem_rdata),
    .o_valid             (o_valid),
    .o_instruction       (o_instruction),
    .o_pc                (o_pc),
    .o_pcplus4           (o_pcplus4)
  );

  assign i_imem_gnt = o_imem_req & gntEn & i_areset_n;

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Expected architectural stream for a new fetch epoch (reset release or redirect).
  task automatic startEpoch(input logic [31:0] base);
    logic [31:0] a;
    expQ.delete();
    a = base & 32'hFFFF_FFFC;
    for (int i = 0; i < 256; i++) begin
      expQ.push_back(a);
      a = a + 32'd4;
    end
    epochConsumed = 0;
  endtask

  task automatic applyStimulus(input logic stall, input logic decRd, input logic [31:0] decAddr,
                               input logic exRd, input logic [31:0] exAddr);
    i_stall             = stall;
    i_dec_redirect      = decRd;
    i_dec_redirect_addr = decAddr;
    i_ex_redirect       = exRd;
    i_ex_redirect_addr  = exAddr;
    if (decRd || exRd) startEpoch(exRd ? exAddr : decAddr);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doRedirect(input logic decRd, input logic [31:0] decAddr,
                            input logic exRd, input logic [31:0] exAddr);
    applyStimulus(i_stall, decRd, decAddr, exRd, exAddr);
    #1;
    checkOutput("redirect_req_low", {31'b0, o_imem_req}, 32'd0);
    @(posedge clk);
    #1;
    i_dec_redirect = 1'b0;
    i_ex_redirect  = 1'b0;
  endtask

  task automatic waitFirst(input string name, input int budget);
    int n = 0;
    while (epochConsumed == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput(name, {31'b0, (epochConsumed > 0)}, 32'd1);
  endtask

  // Instruction memory: grants sampled at negedge, responses returned in order after latency.
  initial begin
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = '0;
    gntEn         = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = '0;
      if (pendQ.size() > 0 && pendQ[0].ready <= cycle) begin
        memP = pendQ.pop_front();
        i_imem_rvalid = 1'b1;
        i_imem_rdata  = memWord(memP.addr);
      end
      gntEn = ($urandom_range(0, 99) < gntPct);
      @(negedge clk);
      if (!i_areset_n) begin
        pendQ.delete();
        lastReady     = 0;
        i_imem_rvalid = 1'b0;
        gntEn         = 1'b0;
      end else if (o_imem_req && i_imem_gnt) begin
        memP.addr  = o_imem_addr;
        memP.ready = cycle + int'($urandom_range(latMin, latMax));
        if (memP.ready < lastReady) memP.ready = lastReady;
        lastReady = memP.ready;
        pendQ.push_back(memP);
      end
    end
  end

  // Decode-side monitor: every consumed head is checked against the scoreboard.
  initial begin
    logic [31:0] e;
    logic [31:0] ePlus4;
    forever begin
      @(negedge clk);
      if (i_areset_n) begin
        checkOutput("outstanding_bound", {31'b0, (dut.r_outstanding <= DEPTH)}, 32'd1);
        checkOutput("drop_bound", {31'b0, (dut.r_drop <= DEPTH)}, 32'd1);
        if (i_imem_rvalid) checkOutput("rvalid_legal", {31'b0, (dut.r_outstanding != 0)}, 32'd1);
        if (o_valid && !i_stall && !i_dec_redirect && !i_ex_redirect) begin
          if (expQ.size() == 0) begin
            numChecks++;
            numFails++;
            $display("[TB] FAIL scoreboard_empty: consumed pc %h, expected no instruction", o_pc);
          end else begin
            e = expQ.pop_front();
            ePlus4 = e + 32'd4;
            checkOutput("pc", o_pc, e);
            checkOutput("pcplus4", o_pcplus4, ePlus4);
            checkOutput("instruction", o_instruction, memWord(e));
            epochConsumed++;
            totalConsumed++;
          end
        end else if (!o_valid) begin
          checkOutput("idle_zero", o_instruction | o_pc | o_pcplus4, 32'd0);
        end
      end
    end
  end

  initial begin
    int found;
    int sinceEpoch;
    int sel;
    i_areset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    waitCycles(3);
    checkOutput("reset_valid", {31'b0, o_valid}, 32'd0);
    checkOutput("reset_instruction", o_instruction, 32'd0);
    checkOutput("reset_pc", o_pc, 32'd0);
    checkOutput("reset_pcplus4", o_pcplus4, 32'd0);
    checkOutput("reset_req", {31'b0, o_imem_req}, 32'd0);
    checkOutput("reset_addr", o_imem_addr, RESET_PC);

    i_areset_n = 1'b1;
    startEpoch(RESET_PC);
    #1;
    checkOutput("first_req", {31'b0, o_imem_req}, 32'd1);
    checkOutput("first_addr", o_imem_addr, RESET_PC);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #3;
      checkOutput("stream_req", {31'b0, o_imem_req}, 32'd1);
      checkOutput("stream_addr", o_imem_addr, RESET_PC + 32'(4 * i));
      if (i == 1) checkOutput("latency_not_yet", {31'b0, o_valid}, 32'd0);
      if (i == 2) checkOutput("latency_valid", {31'b0, o_valid}, 32'd1);
    end
    waitCycles(10);

    i_stall = 1'b1;
    waitCycles(4);
    #2;
    checkOutput("stall_req_low", {31'b0, o_imem_req}, 32'd0);
    waitCycles(1);
    i_stall = 1'b0;
    waitCycles(10);

    latMin = 4;
    latMax = 4;
    found  = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      waitCycles(1);
      #1;
      if (pendQ.size() == 2 && !i_imem_rvalid) found = 1;
    end
    checkOutput("two_in_flight", found, 32'd1);
    doRedirect(1'b1, 32'h0000_0100, 1'b0, 32'd0);
    latMin = 1;
    latMax = 1;
    waitFirst("dec_redirect_first", 30);
    waitCycles(5);

    doRedirect(1'b1, 32'h0000_0200, 1'b1, 32'h0000_0300);
    waitFirst("ex_priority_first", 20);
    waitCycles(5);

    doRedirect(1'b1, 32'h0000_0103, 1'b0, 32'd0);
    checkOutput("align_addr", o_imem_addr, 32'h0000_0100);
    waitFirst("align_first", 20);
    waitCycles(5);

    doRedirect(1'b0, 32'd0, 1'b1, 32'hFFFF_FFF8);
    waitFirst("wrap_first", 20);
    waitCycles(8);
    checkOutput("wrap_progress", {31'b0, (epochConsumed >= 3)}, 32'd1);

    latMin     = 1;
    latMax     = 5;
    gntPct     = 60;
    sinceEpoch = 0;
    for (int i = 0; i < 400; i++) begin
      sinceEpoch++;
      i_stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0 || sinceEpoch > 60) begin
        sel = int'($urandom_range(0, 2));
        applyStimulus(i_stall, (sel != 1), $urandom, (sel != 0), $urandom);
        sinceEpoch = 0;
      end else begin
        i_dec_redirect = 1'b0;
        i_ex_redirect  = 1'b0;
      end
      waitCycles(1);
    end
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    latMin = 1;
    latMax = 1;
    gntPct = 100;
    waitCycles(20);

    #2;
    i_areset_n = 1'b0;
    #1;
    checkOutput("midreset_valid", {31'b0, o_valid}, 32'd0);
    checkOutput("midreset_instruction", o_instruction, 32'd0);
    checkOutput("midreset_pc", o_pc, 32'd0);
    checkOutput("midreset_req", {31'b0, o_imem_req}, 32'd0);
    checkOutput("midreset_addr", o_imem_addr, RESET_PC);
    waitCycles(2);
    i_areset_n = 1'b1;
    startEpoch(RESET_PC);
    waitFirst("restart_first", 20);
    waitCycles(10);
    checkOutput("restart_progress", {31'b0, (epochConsumed >= 5)}, 32'd1);
    checkOutput("total_progress", {31'b0, (totalConsumed > 80)}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
